// File: rtl/nebula_pkg.sv
// nebula_pkg: shared NoC types and constants.
//  noc_flit_t    : 32-bit flit {dest_x, dest_y, payload}
//  PORT_*        : router port indices (LOCAL, NORTH, EAST, SOUTH, WEST)
//  mesh_status_t : packed layout of the fabric status_reg
//  node_idx_w()  : bit width of a node index for a given node count
package nebula_pkg;

  localparam int NUM_PORTS    = 5;
  localparam int PORT_LOCAL   = 0;
  localparam int PORT_NORTH   = 1;
  localparam int PORT_EAST    = 2;
  localparam int PORT_SOUTH   = 3;
  localparam int PORT_WEST    = 4;
  localparam int MESH_MAX_DIM = 8;

  typedef struct packed {
    logic [3:0]  dest_x;
    logic [3:0]  dest_y;
    logic [23:0] payload;
  } noc_flit_t;

  typedef struct packed {
    logic [7:0] err_cnt;
    logic [7:0] occupancy;
    logic [7:0] num_nodes;
    logic [3:0] rsvd;
    logic       any_full;
    logic       deadlock;
    logic       any_nonempty;
    logic       system_ready;
  } mesh_status_t;

  function automatic int node_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nebula_inj_fifo.sv
// nebula_inj_fifo: synchronous FIFO of noc_flit_t, one per mesh node.
//  clk, rst_n (sync, active-low) ; push/din write side ; pop/dout read side
//  full, empty, count status. A push while full is taken only if a pop
//  frees a slot in the same cycle.
module nebula_inj_fifo
  import nebula_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  noc_flit_t din,
  input  logic      pop,
  output noc_flit_t dout,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count
);

  noc_flit_t  mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        wr_en, rd_en;

  assign count = wptr - rptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (wptr == rptr);
  assign dout  = mem[rptr[AW-1:0]];
  assign rd_en = pop & !empty;
  assign wr_en = push & (!full | rd_en);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/nebula_router.sv
// nebula_router: 5-port XY-routed mesh router with one output register
// per port. Routes X first (EAST/WEST), then Y (SOUTH = increasing row),
// then LOCAL. Inputs win outputs in fixed priority, lowest port first.
//  in_valid/in_flit/in_ready   : per-port input handshake
//  out_valid/out_flit/out_ready: per-port output handshake
module nebula_router
  import nebula_pkg::*;
#(
  parameter int X = 0,
  parameter int Y = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] in_valid,
  input  noc_flit_t            in_flit [NUM_PORTS],
  output logic [NUM_PORTS-1:0] in_ready,
  output logic [NUM_PORTS-1:0] out_valid,
  output noc_flit_t            out_flit [NUM_PORTS],
  input  logic [NUM_PORTS-1:0] out_ready
);

  localparam logic [3:0] XC = 4'(X);
  localparam logic [3:0] YC = 4'(Y);

  function automatic logic [2:0] route(input noc_flit_t f);
    if (f.dest_x > XC) return 3'(PORT_EAST);
    if (f.dest_x < XC) return 3'(PORT_WEST);
    if (f.dest_y > YC) return 3'(PORT_SOUTH);
    if (f.dest_y < YC) return 3'(PORT_NORTH);
    return 3'(PORT_LOCAL);
  endfunction

  logic [2:0]           sel [NUM_PORTS];
  logic [NUM_PORTS-1:0] taken;

  // An output register accepts only when already empty, so in_ready never
  // depends on a neighbour's ready and the mesh has no combinational loop.
  always_comb begin
    taken    = '0;
    in_ready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel[i] = route(in_flit[i]);
      if (in_valid[i] && !out_valid[sel[i]] && !taken[sel[i]]) begin
        in_ready[i]   = 1'b1;
        taken[sel[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) out_valid <= '0;
    else        out_valid <= (out_valid & ~out_ready) | taken;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++)
      if (in_ready[i]) out_flit[sel[i]] <= in_flit[i];
  end

endmodule

// File: rtl/nebula_mesh_fabric.sv
// nebula_mesh_fabric: MESH_WIDTH x MESH_HEIGHT mesh of nebula_router with
// XY links, per-node injection FIFOs fed from one injection port, and one
// round-robin ejection port draining every router's local output.
//  inj_valid/inj_node/inj_flit/inj_ready : injection (node >= NUM_NODES is dropped, counted in err_cnt)
//  ej_valid/ej_node/ej_flit/ej_ready     : registered ejection port
//  status_reg, perf_counter, system_ready, deadlock_det : status
// Optional: define NEBULA_MESH_WATCHDOG_EN to build the deadlock watchdog.
module nebula_mesh_fabric
  import nebula_pkg::*;
#(
  parameter int MESH_WIDTH      = 4,
  parameter int MESH_HEIGHT     = 4,
  parameter int NUM_NODES       = MESH_WIDTH * MESH_HEIGHT,
  parameter int INJ_FIFO_DEPTH  = 4,
  parameter int INIT_CYCLES     = 16,
  parameter int WATCHDOG_CYCLES = 1024,
  localparam int NW = node_idx_w(MESH_WIDTH * MESH_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inj_valid,
  input  logic [NW:0]   inj_node,
  input  noc_flit_t     inj_flit,
  output logic          inj_ready,
  output logic          ej_valid,
  output logic [NW-1:0] ej_node,
  output noc_flit_t     ej_flit,
  input  logic          ej_ready,
  output logic [31:0]   status_reg,
  output logic [31:0]   perf_counter,
  output logic          system_ready,
  output logic          deadlock_det
);

  localparam int CW = $clog2(INJ_FIFO_DEPTH) + 1;
  localparam int IW = $clog2(INIT_CYCLES + 1);

  if (MESH_WIDTH < 2 || MESH_WIDTH > MESH_MAX_DIM || MESH_HEIGHT < 2 ||
      MESH_HEIGHT > MESH_MAX_DIM || NUM_NODES != MESH_WIDTH * MESH_HEIGHT ||
      INJ_FIFO_DEPTH < 2 || (INJ_FIFO_DEPTH & (INJ_FIFO_DEPTH - 1)) != 0 ||
      INIT_CYCLES < 1 || WATCHDOG_CYCLES < 1) begin : g_param_err
    $error("nebula_mesh_fabric: parameter out of range");
  end

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [NUM_NODES-1:0] f_full, f_empty, f_push, f_pop, loc_v, grant;
  noc_flit_t            f_head  [NUM_NODES];
  logic [CW-1:0]        f_count [NUM_NODES];
  logic [NUM_PORTS-1:0] r_iv [NUM_NODES], r_ir [NUM_NODES];
  logic [NUM_PORTS-1:0] r_ov [NUM_NODES], r_or [NUM_NODES];
  noc_flit_t            r_if [NUM_NODES][NUM_PORTS], r_of [NUM_NODES][NUM_PORTS];

  logic          valid_node, inj_fire, ej_load, found;
  logic [NW-1:0] win, ptr;
  int            idx, occ_sum;
  logic [IW-1:0] init_cnt;
  logic [7:0]    err_cnt;
  logic [31:0]   inj_cnt;
  mesh_status_t  status_d, status_q;

  assign valid_node = (inj_node < (NW+1)'(NUM_NODES));
  assign inj_ready  = system_ready & (!valid_node | !f_full[inj_node[NW-1:0]]);
  assign inj_fire   = inj_valid & inj_ready;
  assign ej_load    = !ej_valid | ej_ready;

  for (genvar n = 0; n < NUM_NODES; n++) begin : g_node
    localparam int X = n % MESH_WIDTH;
    localparam int Y = n / MESH_WIDTH;

    assign f_push[n] = inj_fire & valid_node & (inj_node[NW-1:0] == NW'(n));
    assign f_pop[n]  = !f_empty[n] & r_ir[n][PORT_LOCAL];

    nebula_inj_fifo #(.DEPTH(INJ_FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push(f_push[n]), .din(inj_flit),
      .pop(f_pop[n]), .dout(f_head[n]), .full(f_full[n]),
      .empty(f_empty[n]), .count(f_count[n])
    );

    assign r_iv[n][PORT_LOCAL] = !f_empty[n];
    assign r_if[n][PORT_LOCAL] = f_head[n];
    assign r_or[n][PORT_LOCAL] = grant[n];
    assign loc_v[n]            = r_ov[n][PORT_LOCAL];

    // Edge ports see no traffic and sink whatever is routed off the mesh.
    if (Y > 0) begin : g_n
      assign r_iv[n][PORT_NORTH] = r_ov[n-MESH_WIDTH][PORT_SOUTH];
      assign r_if[n][PORT_NORTH] = r_of[n-MESH_WIDTH][PORT_SOUTH];
      assign r_or[n][PORT_NORTH] = r_ir[n-MESH_WIDTH][PORT_SOUTH];
    end else begin : g_n_edge
      assign r_iv[n][PORT_NORTH] = 1'b0;
      assign r_if[n][PORT_NORTH] = '0;
      assign r_or[n][PORT_NORTH] = 1'b1;
    end
    if (Y < MESH_HEIGHT - 1) begin : g_s
      assign r_iv[n][PORT_SOUTH] = r_ov[n+MESH_WIDTH][PORT_NORTH];
      assign r_if[n][PORT_SOUTH] = r_of[n+MESH_WIDTH][PORT_NORTH];
      assign r_or[n][PORT_SOUTH] = r_ir[n+MESH_WIDTH][PORT_NORTH];
    end else begin : g_s_edge
      assign r_iv[n][PORT_SOUTH] = 1'b0;
      assign r_if[n][PORT_SOUTH] = '0;
      assign r_or[n][PORT_SOUTH] = 1'b1;
    end
    if (X < MESH_WIDTH - 1) begin : g_e
      assign r_iv[n][PORT_EAST] = r_ov[n+1][PORT_WEST];
      assign r_if[n][PORT_EAST] = r_of[n+1][PORT_WEST];
      assign r_or[n][PORT_EAST] = r_ir[n+1][PORT_WEST];
    end else begin : g_e_edge
      assign r_iv[n][PORT_EAST] = 1'b0;
      assign r_if[n][PORT_EAST] = '0;
      assign r_or[n][PORT_EAST] = 1'b1;
    end
    if (X > 0) begin : g_w
      assign r_iv[n][PORT_WEST] = r_ov[n-1][PORT_EAST];
      assign r_if[n][PORT_WEST] = r_of[n-1][PORT_EAST];
      assign r_or[n][PORT_WEST] = r_ir[n-1][PORT_EAST];
    end else begin : g_w_edge
      assign r_iv[n][PORT_WEST] = 1'b0;
      assign r_if[n][PORT_WEST] = '0;
      assign r_or[n][PORT_WEST] = 1'b1;
    end

    nebula_router #(.X(X), .Y(Y)) u_router (
      .clk(clk), .rst_n(rst_n),
      .in_valid(r_iv[n]), .in_flit(r_if[n]), .in_ready(r_ir[n]),
      .out_valid(r_ov[n]), .out_flit(r_of[n]), .out_ready(r_or[n])
    );
  end

  // Round-robin search from ptr; only the winner's local out_ready is raised.
  always_comb begin
    found = 1'b0;
    win   = '0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < NUM_NODES; k++) begin
      idx = (int'(ptr) + k) % NUM_NODES;
      if (!found && loc_v[idx]) begin
        found = 1'b1;
        win   = NW'(idx);
      end
    end
    if (ej_load && found) grant[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ej_valid <= 1'b0;
      ej_node  <= '0;
      ej_flit  <= '0;
      ptr      <= '0;
    end else if (ej_load) begin
      ej_valid <= found;
      if (found) begin
        ej_node <= win;
        ej_flit <= r_of[win][PORT_LOCAL];
        ptr     <= (win == NW'(NUM_NODES - 1)) ? '0 : win + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_cnt     <= '0;
      system_ready <= 1'b0;
      err_cnt      <= '0;
      inj_cnt      <= '0;
      perf_counter <= '0;
      status_q     <= '0;
    end else begin
      if (!system_ready) begin
        if (init_cnt == IW'(INIT_CYCLES - 1)) system_ready <= 1'b1;
        else                                  init_cnt     <= init_cnt + 1'b1;
      end
      if (inj_fire && !valid_node) err_cnt      <= sat_inc8(err_cnt);
      if (inj_fire &&  valid_node) inj_cnt      <= sat_inc32(inj_cnt);
      if (ej_valid && ej_ready)    perf_counter <= sat_inc32(perf_counter);
      status_q <= status_d;
    end
  end

  always_comb begin
    occ_sum = 0;
    for (int n = 0; n < NUM_NODES; n++) occ_sum += int'(f_count[n]);
    status_d              = '0;
    status_d.system_ready = system_ready;
    status_d.any_nonempty = ~&f_empty;
    status_d.deadlock     = deadlock_det;
    status_d.any_full     = |f_full;
    status_d.num_nodes    = 8'(NUM_NODES);
    status_d.occupancy    = (occ_sum > 255) ? 8'hFF : 8'(occ_sum);
    status_d.err_cnt      = err_cnt;
  end

  assign status_reg = status_q;

`ifdef NEBULA_MESH_WATCHDOG_EN
  localparam int SW = $clog2(WATCHDOG_CYCLES + 1);
  logic [SW-1:0] stall_cnt;
  logic          pending;

  assign pending = (inj_cnt != perf_counter) | ~&f_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt    <= '0;
      deadlock_det <= 1'b0;
    end else if (ej_valid && ej_ready) begin
      stall_cnt <= '0;
    end else if (pending && !deadlock_det) begin
      if (stall_cnt == SW'(WATCHDOG_CYCLES - 1)) deadlock_det <= 1'b1;
      else                                      stall_cnt    <= stall_cnt + 1'b1;
    end
  end
`else
  assign deadlock_det = 1'b0;
`endif

endmodule

// File: tb/tb_nebula_mesh_fabric.sv
// Directed bench for nebula_mesh_fabric (default 4x4 mesh, FIFO depth 4).
// Pipeline timing assumed by the expected values: a flit pushed at edge k
// sits in its FIFO, reaches the router local output at k+1 and the ejection
// register at k+2.
module tb_nebula_mesh_fabric;
  import nebula_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, inj_valid, inj_ready, ej_valid, ej_ready;
  logic        system_ready, deadlock_det;
  logic [4:0]  inj_node;
  logic [3:0]  ej_node;
  noc_flit_t   inj_flit, ej_flit;
  logic [31:0] status_reg, perf_counter;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  nebula_mesh_fabric dut (
    .clk(clk), .rst_n(rst_n),
    .inj_valid(inj_valid), .inj_node(inj_node), .inj_flit(inj_flit), .inj_ready(inj_ready),
    .ej_valid(ej_valid), .ej_node(ej_node), .ej_flit(ej_flit), .ej_ready(ej_ready),
    .status_reg(status_reg), .perf_counter(perf_counter),
    .system_ready(system_ready), .deadlock_det(deadlock_det)
  );

  function automatic noc_flit_t mk(input int node, input int pay);
    noc_flit_t f;
    f.dest_x  = 4'(node % 4);
    f.dest_y  = 4'(node / 4);
    f.payload = 24'(pay);
    return f;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic inject(input int node, input int dest, input int pay);
    inj_valid = 1'b1;
    inj_node  = 5'(node);
    inj_flit  = mk(dest, pay);
    tick();
    inj_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; inj_valid = 1'b0; inj_node = '0; inj_flit = '0; ej_ready = 1'b1;
    tick(); tick();
    vectors++; if (ej_valid !== 1'b0) begin errors++; $display("FAIL rst_ej_valid: got %b want 0", ej_valid); end
    vectors++; if (status_reg !== 32'h0) begin errors++; $display("FAIL rst_status: got %h want 00000000", status_reg); end
    vectors++; if (perf_counter !== 32'h0) begin errors++; $display("FAIL rst_perf: got %0d want 0", perf_counter); end
    vectors++; if (system_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", system_ready); end
    vectors++; if (deadlock_det !== 1'b0) begin errors++; $display("FAIL rst_deadlock: got %b want 0", deadlock_det); end
  endtask

  task automatic test_init;
    rst_n = 1'b1;
    repeat (15) tick();
    vectors++; if (system_ready !== 1'b0) begin errors++; $display("FAIL init_15: got %b want 0", system_ready); end
    tick();
    vectors++; if (system_ready !== 1'b1) begin errors++; $display("FAIL init_16: got %b want 1", system_ready); end
    vectors++; if (status_reg !== 32'h0000_1000) begin errors++; $display("FAIL init_status16: got %h want 00001000", status_reg); end
    tick();
    vectors++; if (status_reg !== 32'h0000_1001) begin errors++; $display("FAIL init_status17: got %h want 00001001", status_reg); end
  endtask

  task automatic test_single;
    int n;
    inj_valid = 1'b1; inj_node = 5'd0; inj_flit = mk(0, 'h0A0A);
    #1;
    vectors++; if (inj_ready !== 1'b1) begin errors++; $display("FAIL single_inj_ready: got %b want 1", inj_ready); end
    tick();
    inj_valid = 1'b0;
    n = 0;
    while (!ej_valid && n < 10) begin tick(); n++; end
    vectors++; if (n !== 2) begin errors++; $display("FAIL single_latency: got %0d want 2", n); end
    vectors++; if (ej_node !== 4'd0) begin errors++; $display("FAIL single_node: got %0d want 0", ej_node); end
    vectors++; if (ej_flit !== mk(0, 'h0A0A)) begin errors++; $display("FAIL single_flit: got %h want %h", ej_flit, mk(0, 'h0A0A)); end
    tick();
    vectors++; if (perf_counter !== 32'd1) begin errors++; $display("FAIL single_perf: got %0d want 1", perf_counter); end
    vectors++; if (ej_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", ej_valid); end
  endtask

  // With ej_ready low the path holds 6 flits: ejection register, router
  // local output register and 4 FIFO entries.
  task automatic test_backpressure;
    int acc, got;
    ej_ready = 1'b0;
    acc = 0;
    for (int t = 0; t < 20; t++) begin
      inj_valid = 1'b1; inj_node = 5'd5; inj_flit = mk(5, 'h100 + acc);
      #1;
      if (!inj_ready) break;
      tick();
      acc++;
    end
    inj_valid = 1'b0;
    vectors++; if (acc !== 6) begin errors++; $display("FAIL bp_accepted: got %0d want 6", acc); end
    vectors++; if (inj_ready !== 1'b0) begin errors++; $display("FAIL bp_inj_ready: got %b want 0", inj_ready); end
    tick();
    vectors++; if (status_reg[3] !== 1'b1) begin errors++; $display("FAIL bp_full_bit: got %b want 1", status_reg[3]); end
    vectors++; if (status_reg[23:16] !== 8'd4) begin errors++; $display("FAIL bp_occupancy: got %0d want 4", status_reg[23:16]); end
    ej_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (ej_valid) begin
        vectors++; if (ej_flit.payload !== 24'('h100 + got) || ej_node !== 4'd5) begin
          errors++; $display("FAIL bp_order: got node %0d pay %h want node 5 pay %h", ej_node, ej_flit.payload, 'h100 + got);
        end
        got++;
      end
      tick();
    end
    vectors++; if (got !== 6) begin errors++; $display("FAIL bp_count: got %0d want 6", got); end
    vectors++; if (perf_counter !== 32'd7) begin errors++; $display("FAIL bp_perf: got %0d want 7", perf_counter); end
    tick(); tick();
    vectors++; if (status_reg !== 32'h0000_1001) begin errors++; $display("FAIL bp_status_idle: got %h want 00001001", status_reg); end
  endtask

  // X parks in the ejection register from node 15 (ptr wraps to 0), then
  // nodes 0, 5, 15 all hold a flit at their local outputs.
  task automatic test_round_robin;
    int exp_node [4] = '{15, 0, 5, 15};
    ej_ready = 1'b0;
    inject(15, 15, 'h200);
    inject(0, 0, 'h201);
    inject(5, 5, 'h202);
    inject(15, 15, 'h203);
    repeat (4) tick();
    ej_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vectors++; if (ej_valid !== 1'b1 || ej_node !== 4'(exp_node[k]) || ej_flit.payload !== 24'('h200 + k)) begin
        errors++; $display("FAIL rr_%0d: got v%b node %0d pay %h want v1 node %0d pay %h",
                           k, ej_valid, ej_node, ej_flit.payload, exp_node[k], 'h200 + k);
      end
      tick();
    end
    vectors++; if (ej_valid !== 1'b0) begin errors++; $display("FAIL rr_end: got %b want 0", ej_valid); end
    vectors++; if (perf_counter !== 32'd11) begin errors++; $display("FAIL rr_perf: got %0d want 11", perf_counter); end
  endtask

  task automatic test_bad_node;
    logic seen;
    inj_valid = 1'b1; inj_node = 5'd16; inj_flit = mk(3, 'h300);
    #1;
    vectors++; if (inj_ready !== 1'b1) begin errors++; $display("FAIL bad_inj_ready: got %b want 1", inj_ready); end
    tick();
    inj_valid = 1'b0;
    seen = 1'b0;
    repeat (6) begin if (ej_valid) seen = 1'b1; tick(); end
    vectors++; if (seen !== 1'b0) begin errors++; $display("FAIL bad_ejected: got %b want 0", seen); end
    vectors++; if (status_reg[31:24] !== 8'd1) begin errors++; $display("FAIL bad_err_cnt: got %0d want 1", status_reg[31:24]); end
    vectors++; if (perf_counter !== 32'd11) begin errors++; $display("FAIL bad_perf: got %0d want 11", perf_counter); end
  endtask

  task automatic test_reset_mid;
    ej_ready = 1'b0;
    inject(1, 1, 'h401); inject(1, 1, 'h402); inject(1, 1, 'h403);
    inject(2, 2, 'h404); inject(2, 2, 'h405);
    inject(3, 3, 'h406); inject(3, 3, 'h407);
    repeat (4) tick();
    vectors++; if (status_reg[1] !== 1'b1 || status_reg[23:16] !== 8'd3) begin
      errors++; $display("FAIL mid_pre: got nonempty %b occ %0d want 1 occ 3", status_reg[1], status_reg[23:16]);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++; if (ej_valid !== 1'b0 || perf_counter !== 32'd0 || status_reg !== 32'h0) begin
      errors++; $display("FAIL mid_reset: got ej_valid %b perf %0d status %h want 0 0 00000000", ej_valid, perf_counter, status_reg);
    end
    tick();
    vectors++; if (status_reg !== 32'h0000_1000) begin errors++; $display("FAIL mid_after: got %h want 00001000", status_reg); end
    repeat (20) tick();
    vectors++; if (ej_valid !== 1'b0 || perf_counter !== 32'd0) begin
      errors++; $display("FAIL mid_flushed: got ej_valid %b perf %0d want 0 0", ej_valid, perf_counter);
    end
  endtask

  task automatic test_watchdog;
`ifdef NEBULA_MESH_WATCHDOG_EN
    ej_ready = 1'b0;
    inject(0, 0, 'h500);
    inject(0, 0, 'h501);
    repeat (1040) tick();
    vectors++; if (deadlock_det !== 1'b1 || status_reg[2] !== 1'b1) begin
      errors++; $display("FAIL wd_set: got %b/%b want 1/1", deadlock_det, status_reg[2]);
    end
    ej_ready = 1'b1;
    repeat (10) tick();
    vectors++; if (deadlock_det !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %b want 1", deadlock_det); end
`else
    vectors++; if (deadlock_det !== 1'b0 || status_reg[2] !== 1'b0) begin
      errors++; $display("FAIL wd_off: got %b/%b want 0/0", deadlock_det, status_reg[2]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_init();
    test_single();
    test_backpressure();
    test_round_robin();
    test_bad_node();
    test_reset_mid();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded 500000 ns");
    $fatal(1);
  end

endmodule
